// File: rtl/mem_responder.sv
// mem_responder: single-port word RAM acting as the responder on the core's
// memory bus. Accepts one read/write request at a time in IDLE, waits a fixed
// number of cycles, performs the access on the edge that enters RESP and
// signals completion with a one-cycle mem_data_ready pulse.
// Optional feature: define MEM_RAND_WAIT_EN to add 0..3 pseudo-random extra
// wait cycles per access, drawn from an 8-bit Galois LFSR.
module mem_responder #(
  parameter int          ADDR_WIDTH  = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        mem_addr_ready,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  output logic        mem_data_ready,
  output logic        mem_fault
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
`ifdef MEM_RAND_WAIT_EN
  localparam int CNT_W = 5;
`else
  localparam int CNT_W = 4;
`endif

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [CNT_W-1:0] total_w;

  logic [31:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] idx_q;
  logic [31:0]           wdata_q;
  logic [3:0]            wstrb_q;
  logic                  write_q;
  logic                  in_range_q;

  logic                  accept;
  logic                  req_write;
  logic                  req_in_range;
  logic [ADDR_WIDTH-1:0] req_idx;

  logic                  acc_now;
  logic                  use_live;
  logic [ADDR_WIDTH-1:0] acc_idx;
  logic [31:0]           acc_wdata;
  logic [3:0]            acc_wstrb;
  logic                  acc_write;
  logic                  acc_in_range;

  // Byte-lane bits of the address are don't-care: lanes come from the strobe.
  logic unused_addr_lanes;
  assign unused_addr_lanes = ^mem_addr[1:0];

  assign accept       = (state == IDLE) && mem_addr_ready && (mem_read || mem_write);
  assign req_write    = mem_write && !mem_read;
  assign req_in_range = (mem_addr[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);
  assign req_idx      = mem_addr[ADDR_WIDTH+1:2];

`ifdef MEM_RAND_WAIT_EN
  logic [7:0] lfsr;

  // LFSR steps once per accepted request; its low bits set the extra waits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr <= 8'h01;
    end else if (accept) begin
      lfsr <= {1'b0, lfsr[7:1]} ^ (lfsr[0] ? 8'hB8 : 8'h00);
    end
  end

  assign total_w = CNT_W'(WAIT_STATES) + CNT_W'(lfsr[1:0]);
`else
  assign total_w = CNT_W'(WAIT_STATES);
`endif

  // With zero waits the access happens on the acceptance edge itself, so the
  // live bus values are used; otherwise the latched request is used.
  assign use_live     = (state == IDLE);
  assign acc_idx      = use_live ? req_idx      : idx_q;
  assign acc_wdata    = use_live ? mem_wdata    : wdata_q;
  assign acc_wstrb    = use_live ? mem_wstrb    : wstrb_q;
  assign acc_write    = use_live ? req_write    : write_q;
  assign acc_in_range = use_live ? req_in_range : in_range_q;
  assign acc_now      = !rst && ((accept && (total_w == '0)) ||
                                 ((state == WAIT) && (cnt == CNT_W'(1))));

  // State and wait counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  // Next-state and wait-counter logic.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          if (total_w == '0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = total_w;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request kind and range result, cleared by reset so a reset drops the access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_q    <= 1'b0;
      in_range_q <= 1'b0;
    end else if (accept) begin
      write_q    <= req_write;
      in_range_q <= req_in_range;
    end
  end

  // Request payload captured at acceptance.
  always_ff @(posedge clk) begin
    if (accept) begin
      idx_q   <= req_idx;
      wdata_q <= mem_wdata;
      wstrb_q <= mem_wstrb;
    end
  end

  // Strobed write into the array; out-of-range writes are dropped.
  always_ff @(posedge clk) begin
    if (acc_now && acc_write && acc_in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (acc_wstrb[b]) mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
      end
    end
  end

  // Read data register; holds its value across writes and idle cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_rdata <= '0;
    end else if (acc_now && !acc_write) begin
      mem_rdata <= acc_in_range ? mem[acc_idx] : 32'h0;
    end
  end

  assign mem_data_ready = (state == RESP);
  assign mem_fault      = (state == RESP) && !in_range_q;

endmodule
